// File: rtl/comparator_pkg.sv
// Shared definitions for the equality-comparator BIST: state encoding,
// default operand width and the exhaustive vector count.
package comparator_pkg;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_RUN  = 2'd1;
   localparam state_t ST_DONE = 2'd2;

   localparam int DEFAULT_WIDTH = 4;
   localparam int SETTLE_W      = 4;

   // Number of A/B pairs in an exhaustive run.
   function automatic int vector_count(input int width);
      return 1 << (2 * width);
   endfunction

endpackage

// File: rtl/comparator_if.sv
// A/B/E link between the BIST initiator (master) and the comparator under test (slave).
interface comparator_if #(
   parameter int WIDTH = comparator_pkg::DEFAULT_WIDTH
);
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             E;

   modport master (output A, output B, input E);
   modport slave  (input A, input B, output E);
endinterface

// File: rtl/bist_vector_counter.sv
// Pair index and settle counter for the BIST. One pair is held for SETTLE+1
// cycles; the index stops on the last pair instead of wrapping.
module bist_vector_counter
   import comparator_pkg::*;
#(
   parameter int WIDTH  = DEFAULT_WIDTH,
   parameter int SETTLE = 0
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               clear,
   input  logic               advance,
   output logic [2*WIDTH-1:0] idx,
   output logic               sample_now,
   output logic               last_vector
);

   localparam int                  IDX_W      = 2 * WIDTH;
   localparam logic [IDX_W-1:0]    LAST_IDX   = IDX_W'(vector_count(WIDTH) - 1);
   localparam logic [SETTLE_W-1:0] SETTLE_MAX = SETTLE_W'(SETTLE);

   logic [IDX_W-1:0]    idx_r;
   logic [SETTLE_W-1:0] cnt_r;

   // Index and settle counter update.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_r <= {IDX_W{1'b0}};
         cnt_r <= {SETTLE_W{1'b0}};
      end else if (clear) begin
         idx_r <= {IDX_W{1'b0}};
         cnt_r <= {SETTLE_W{1'b0}};
      end else if (advance) begin
         if (cnt_r < SETTLE_MAX) begin
            cnt_r <= cnt_r + SETTLE_W'(1);
         end else if (idx_r != LAST_IDX) begin
            idx_r <= idx_r + IDX_W'(1);
            cnt_r <= {SETTLE_W{1'b0}};
         end
      end
   end

   assign idx         = idx_r;
   assign sample_now  = (cnt_r == SETTLE_MAX);
   assign last_vector = (idx_r == LAST_IDX);

endmodule

// File: rtl/comparator_bist.sv
// BIST engine for a WIDTH-bit equality comparator: sweeps every A/B pair,
// checks E against A==B and keeps error count and first failing pair.
module comparator_bist
   import comparator_pkg::*;
#(
   parameter int WIDTH  = DEFAULT_WIDTH,
   parameter int SETTLE = 0
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   comparator_if.master       cmp,
   output logic               busy,
   output logic               done,
   output logic               pass,
   output logic [2*WIDTH:0]   err_count,
   output logic               fail_valid,
   output logic [WIDTH-1:0]   fail_A,
   output logic [WIDTH-1:0]   fail_B
);

   localparam int IDX_W = 2 * WIDTH;
   localparam int ERR_W = 2 * WIDTH + 1;

   state_t           state_r;
   state_t           state_next_s;
   logic             busy_r;
   logic             done_r;
   logic             busy_next_s;
   logic             done_next_s;
   logic             clear_s;
   logic             advance_s;
   logic             sample_now_s;
   logic             last_vector_s;
   logic             mismatch_s;
   logic [IDX_W-1:0] idx_s;
   logic [WIDTH-1:0] a_s;
   logic [WIDTH-1:0] b_s;
   logic [ERR_W-1:0] err_count_r;
   logic             fail_valid_r;
   logic [WIDTH-1:0] fail_a_r;
   logic [WIDTH-1:0] fail_b_r;

   bist_vector_counter #(
      .WIDTH  (WIDTH),
      .SETTLE (SETTLE)
   ) u_vector_counter (
      .clk         (clk),
      .rst_n       (rst_n),
      .clear       (clear_s),
      .advance     (advance_s),
      .idx         (idx_s),
      .sample_now  (sample_now_s),
      .last_vector (last_vector_s)
   );

   // A start outside RUN restarts the sweep; during RUN it is ignored.
   assign clear_s    = start && (state_r != ST_RUN);
   assign advance_s  = (state_r == ST_RUN);
   assign a_s        = idx_s[IDX_W-1:WIDTH];
   assign b_s        = idx_s[WIDTH-1:0];
   assign mismatch_s = advance_s && sample_now_s && (cmp.E != (a_s == b_s));

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Next-state logic.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (start) state_next_s = ST_RUN;
            else       state_next_s = ST_IDLE;
         end
         ST_RUN: begin
            if (sample_now_s && last_vector_s) state_next_s = ST_DONE;
            else                               state_next_s = ST_RUN;
         end
         ST_DONE: begin
            if (start) state_next_s = ST_RUN;
            else       state_next_s = ST_DONE;
         end
         default: state_next_s = ST_IDLE;
      endcase
   end

   // Status decode from the upcoming state so busy/done leave a flop.
   always_comb begin
      busy_next_s = 1'b0;
      done_next_s = 1'b0;
      case (state_next_s)
         ST_IDLE: begin
            busy_next_s = 1'b0;
            done_next_s = 1'b0;
         end
         ST_RUN: begin
            busy_next_s = 1'b1;
            done_next_s = 1'b0;
         end
         ST_DONE: begin
            busy_next_s = 1'b0;
            done_next_s = 1'b1;
         end
         default: begin
            busy_next_s = 1'b0;
            done_next_s = 1'b0;
         end
      endcase
   end

   // Registered status flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_r <= 1'b0;
         done_r <= 1'b0;
      end else begin
         busy_r <= busy_next_s;
         done_r <= done_next_s;
      end
   end

   // Error count and first-failure capture.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_count_r  <= {ERR_W{1'b0}};
         fail_valid_r <= 1'b0;
         fail_a_r     <= {WIDTH{1'b0}};
         fail_b_r     <= {WIDTH{1'b0}};
      end else if (clear_s) begin
         err_count_r  <= {ERR_W{1'b0}};
         fail_valid_r <= 1'b0;
         fail_a_r     <= {WIDTH{1'b0}};
         fail_b_r     <= {WIDTH{1'b0}};
      end else if (mismatch_s) begin
         err_count_r <= err_count_r + ERR_W'(1);
         if (!fail_valid_r) begin
            fail_valid_r <= 1'b1;
            fail_a_r     <= a_s;
            fail_b_r     <= b_s;
         end
      end
   end

   assign cmp.A      = a_s;
   assign cmp.B      = b_s;
   assign busy       = busy_r;
   assign done       = done_r;
   assign pass       = done_r && (err_count_r == {ERR_W{1'b0}});
   assign err_count  = err_count_r;
   assign fail_valid = fail_valid_r;
   assign fail_A     = fail_a_r;
   assign fail_B     = fail_b_r;

endmodule

// File: tb/tb_comparator_bist.sv
// Directed bench for comparator_bist: two instances (SETTLE=0 and SETTLE=2)
// each driving a behavioural comparator with selectable fault mode.
module tb_comparator_bist;
   import comparator_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst0_n, rst2_n;
   logic       start0, start2;
   logic [1:0] mode0, mode2;

   logic       busy0, done0, pass0, fv0;
   logic [8:0] err0;
   logic [3:0] fa0, fb0;
   logic       busy2, done2, pass2, fv2;
   logic [8:0] err2;
   logic [3:0] fa2, fb2;

   int errors = 0;
   int checks = 0;

   comparator_if #(.WIDTH(4)) if0 ();
   comparator_if #(.WIDTH(4)) if2 ();

   // mode: 0 correct, 1 stuck-at-1, 2 stuck-at-0, 3 inverted
   function automatic logic cmp_model(input logic [3:0] a, input logic [3:0] b, input logic [1:0] m);
      case (m)
         2'd0:    return (a == b);
         2'd1:    return 1'b1;
         2'd2:    return 1'b0;
         2'd3:    return (a != b);
         default: return (a == b);
      endcase
   endfunction

   assign if0.E = cmp_model(if0.A, if0.B, mode0);
   assign if2.E = cmp_model(if2.A, if2.B, mode2);

   comparator_bist #(.WIDTH(4), .SETTLE(0)) dut0 (
      .clk(clk), .rst_n(rst0_n), .start(start0), .cmp(if0.master),
      .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
      .fail_valid(fv0), .fail_A(fa0), .fail_B(fb0)
   );

   comparator_bist #(.WIDTH(4), .SETTLE(2)) dut2 (
      .clk(clk), .rst_n(rst2_n), .start(start2), .cmp(if2.master),
      .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
      .fail_valid(fv2), .fail_A(fa2), .fail_B(fb2)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse0();
      start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
   endtask

   task automatic pulse2();
      start2 = 1'b1;
      @(negedge clk);
      start2 = 1'b0;
   endtask

   initial begin
      rst0_n = 1'b0; rst2_n = 1'b0;
      start0 = 1'b0; start2 = 1'b0;
      mode0  = 2'd0; mode2  = 2'd0;
      tick(3);
      check("rst_busy", busy0, 1'b0);
      check("rst_done", done0, 1'b0);
      check("rst_pass", pass0, 1'b0);
      check("rst_err",  err0,  9'd0);
      check("rst_fv",   fv0,   1'b0);
      check("rst_A",    if0.A, 4'h0);
      check("rst_B",    if0.B, 4'h0);
      rst0_n = 1'b1; rst2_n = 1'b1;
      tick(2);
      check("idle_busy", busy0, 1'b0);

      // Correct comparator, 256 busy cycles
      pulse0();
      check("t1_busy_rise", busy0, 1'b1);
      check("t1_A0", if0.A, 4'h0);
      tick(255);
      check("t1_busy_255", busy0, 1'b1);
      check("t1_done_255", done0, 1'b0);
      check("t1_last_A", if0.A, 4'hF);
      check("t1_last_B", if0.B, 4'hF);
      tick(1);
      check("t1_done", done0, 1'b1);
      check("t1_busy_off", busy0, 1'b0);
      check("t1_pass", pass0, 1'b1);
      check("t1_err", err0, 9'd0);
      check("t1_fv", fv0, 1'b0);
      check("t1_hold_A", if0.A, 4'hF);

      // Stuck-at-1 with an ignored start at cycle 100
      mode0 = 2'd1;
      pulse0();
      check("t2_busy", busy0, 1'b1);
      check("t2_done_clr", done0, 1'b0);
      tick(99);
      start0 = 1'b1;
      tick(1);
      start0 = 1'b0;
      tick(155);
      check("t5_busy_256", busy0, 1'b1);
      check("t5_done_256", done0, 1'b0);
      tick(1);
      check("t5_done_257", done0, 1'b1);
      check("t2_err", err0, 9'd240);
      check("t2_fv", fv0, 1'b1);
      check("t2_fa", fa0, 4'h0);
      check("t2_fb", fb0, 4'h1);
      check("t2_pass", pass0, 1'b0);

      // Restart from DONE clears results; stuck-at-0
      mode0 = 2'd2;
      pulse0();
      check("t5_restart_err", err0, 9'd0);
      check("t5_restart_fv", fv0, 1'b0);
      check("t5_restart_busy", busy0, 1'b1);
      tick(256);
      check("t3_done", done0, 1'b1);
      check("t3_err", err0, 9'd16);
      check("t3_fv", fv0, 1'b1);
      check("t3_fa", fa0, 4'h0);
      check("t3_fb", fb0, 4'h0);

      // Inverted comparator fails every pair
      mode0 = 2'd3;
      pulse0();
      tick(256);
      check("t3_inv_done", done0, 1'b1);
      check("t3_inv_err", err0, 9'h100);
      check("t3_inv_pass", pass0, 1'b0);
      check("t3_inv_fb", fb0, 4'h0);

      // SETTLE=2: each pair held 3 cycles, 768-cycle run
      pulse2();
      check("t4_busy", busy2, 1'b1);
      tick(14);
      check("t4_c14_B", if2.B, 4'h4);
      tick(1);
      check("t4_c15_B", if2.B, 4'h5);
      tick(1);
      check("t4_c16_B", if2.B, 4'h5);
      tick(1);
      check("t4_c17_B", if2.B, 4'h5);
      check("t4_c17_A", if2.A, 4'h0);
      tick(1);
      check("t4_c18_B", if2.B, 4'h6);
      tick(749);
      check("t4_busy_767", busy2, 1'b1);
      check("t4_done_767", done2, 1'b0);
      tick(1);
      check("t4_done", done2, 1'b1);
      check("t4_pass", pass2, 1'b1);
      check("t4_err", err2, 9'd0);

      // Asynchronous reset mid-run at idx 0x7A
      mode0 = 2'd1;
      pulse0();
      tick(122);
      check("t6_A", if0.A, 4'h7);
      check("t6_B", if0.B, 4'hA);
      check("t6_err_pre", err0, 9'd114);
      #2;
      rst0_n = 1'b0;
      #1;
      check("t6_busy", busy0, 1'b0);
      check("t6_A0", if0.A, 4'h0);
      check("t6_B0", if0.B, 4'h0);
      check("t6_err0", err0, 9'd0);
      check("t6_fv0", fv0, 1'b0);
      @(negedge clk);
      rst0_n = 1'b1;
      mode0 = 2'd0;
      tick(3);
      check("t6_idle_busy", busy0, 1'b0);
      check("t6_idle_done", done0, 1'b0);
      pulse0();
      tick(256);
      check("t6_rerun_done", done0, 1'b1);
      check("t6_rerun_pass", pass0, 1'b1);
      check("t6_rerun_A", if0.A, 4'hF);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
